// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch unit for an RV32IC core.
//
// Holds the architectural fetch PC, issues half-word-aligned fetch requests
// to the instruction cache, classifies each returned word as a 32-bit or
// compressed 16-bit instruction and presents it to the decoder with a
// valid/ready handshake. A flush redirects the PC and discards any in-flight
// fetch, letting the cache finish an outstanding request first (DRAIN).
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global stall when low)
//   ic_req_valid/ic_req_addr   -> cache request, held until response
//   ic_resp_valid/ic_resp_data <- cache response pulse and data
//   inst_valid/inst_pc/inst_raw/inst_is_c -> decoder, dec_ready <- decoder
//   pred_next_pc <- predictor next PC for the presented instruction
//   br_flush/br_target <- redirect from the ROB
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_raw,
  output logic        inst_is_c,
  input  logic        dec_ready,
  input  logic [31:0] pred_next_pc,
  input  logic        br_flush,
  input  logic [31:0] br_target
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_raw_q, inst_raw_d;
  logic        inst_is_c_q, inst_is_c_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      pc_q         <= {RESET_PC[31:1], 1'b0};
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      inst_raw_q   <= '0;
      inst_is_c_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_raw_q   <= inst_raw_d;
      inst_is_c_q  <= inst_is_c_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_raw_d   = inst_raw_q;
    inst_is_c_d  = inst_is_c_q;

    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          req_valid_d = 1'b1;
          req_addr_d  = pc_q;
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          if (ic_resp_valid) begin
            inst_valid_d = 1'b1;
            inst_pc_d    = req_addr_q;
            req_valid_d  = 1'b0;
            state_d      = S_HOLD;
            if (ic_resp_data[1:0] == 2'b11) begin
              inst_raw_d  = ic_resp_data;
              inst_is_c_d = 1'b0;
            end else begin
              inst_raw_d  = {16'h0000, ic_resp_data[15:0]};
              inst_is_c_d = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (dec_ready) begin
            pc_d         = {pred_next_pc[31:1], 1'b0};
            inst_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (ic_resp_valid) begin
            req_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Flush overrides everything decided above: the instruction buffer
      // keeps its old contents (only valid drops), and an outstanding cache
      // request is kept alive until its response arrives.
      if (br_flush) begin
        pc_d         = {br_target[31:1], 1'b0};
        inst_valid_d = 1'b0;
        inst_pc_d    = inst_pc_q;
        inst_raw_d   = inst_raw_q;
        inst_is_c_d  = inst_is_c_q;
        req_addr_d   = req_addr_q;
        unique case (state_q)
          S_WAIT, S_DRAIN: begin
            if (ic_resp_valid) begin
              req_valid_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              req_valid_d = 1'b1;
              state_d     = S_DRAIN;
            end
          end
          default: begin
            req_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        endcase
      end
    end
  end

  assign ic_req_valid = req_valid_q;
  assign ic_req_addr  = req_addr_q;
  assign inst_valid   = inst_valid_q;
  assign inst_pc      = inst_pc_q;
  assign inst_raw     = inst_raw_q;
  assign inst_is_c    = inst_is_c_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit: reset, 32-bit and compressed fetches,
// decoder backpressure, flushes in WAIT/HOLD and global-ready freeze.
module tb_ifetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_raw;
  logic        inst_is_c;
  logic        dec_ready;
  logic [31:0] pred_next_pc;
  logic        br_flush;
  logic [31:0] br_target;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_data  (ic_resp_data),
    .inst_valid    (inst_valid),
    .inst_pc       (inst_pc),
    .inst_raw      (inst_raw),
    .inst_is_c     (inst_is_c),
    .dec_ready     (dec_ready),
    .pred_next_pc  (pred_next_pc),
    .br_flush      (br_flush),
    .br_target     (br_target)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_valid"},  {31'd0, ic_req_valid}, 32'd0);
    check_eq({tag, "_inst_valid"}, {31'd0, inst_valid},   32'd0);
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    check_eq({tag, "_req_valid"}, {31'd0, ic_req_valid}, 32'd1);
    check_eq({tag, "_req_addr"},  ic_req_addr,           addr);
  endtask

  task automatic check_inst(input string tag, input logic [31:0] pc,
                            input logic [31:0] raw, input logic is_c);
    check_eq({tag, "_inst_valid"}, {31'd0, inst_valid},   32'd1);
    check_eq({tag, "_inst_pc"},    inst_pc,               pc);
    check_eq({tag, "_inst_raw"},   inst_raw,              raw);
    check_eq({tag, "_inst_is_c"},  {31'd0, inst_is_c},    {31'd0, is_c});
    check_eq({tag, "_req_drop"},   {31'd0, ic_req_valid}, 32'd0);
  endtask

  // One-cycle response pulse.
  task automatic respond(input logic [31:0] data);
    ic_resp_valid = 1'b1;
    ic_resp_data  = data;
    step();
    ic_resp_valid = 1'b0;
  endtask

  // Accept the presented instruction, then let IDLE issue the next request.
  task automatic accept(input logic [31:0] next_pc);
    dec_ready    = 1'b1;
    pred_next_pc = next_pc;
    step();
    dec_ready = 1'b0;
    check_idle_outputs("accept_idle");
    step();
  endtask

  initial begin
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
    dec_ready     = 1'b0;
    pred_next_pc  = '0;
    br_flush      = 1'b0;
    br_target     = '0;

    step();
    step();
    check_idle_outputs("reset");
    check_eq("reset_req_addr", ic_req_addr, 32'h0);
    check_eq("reset_inst_pc",  inst_pc,     32'h0);
    check_eq("reset_inst_raw", inst_raw,    32'h0);
    check_eq("reset_inst_is_c", {31'd0, inst_is_c}, 32'd0);

    rst_in = 1'b0;
    step();
    check_req("first_req", 32'h0);

    // Asynchronous reset in the middle of WAIT clears outputs without a clock edge.
    #2 rst_in = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    step();
    rst_in = 1'b0;
    step();
    check_req("req_after_reset", 32'h0);

    // 32-bit instruction.
    respond(32'h0050_0093);
    check_inst("i32", 32'h0, 32'h0050_0093, 1'b0);
    accept(32'h4);
    check_req("req_seq", 32'h4);

    // Compressed instruction: upper half-word discarded.
    respond(32'h1234_4501);
    check_inst("rvc", 32'h4, 32'h0000_4501, 1'b1);
    accept(32'h6);
    check_req("req_rvc", 32'h6);

    // Backpressure: buffer stable and no new request while dec_ready low.
    respond(32'h00A0_0113);
    for (int i = 0; i < 5; i++) begin
      step();
      check_inst("hold", 32'h6, 32'h00A0_0113, 1'b0);
    end
    accept(32'h101);
    check_req("req_odd_pred", 32'h100);

    // Flush in WAIT before the response: old request drains, late data dropped.
    br_flush  = 1'b1;
    br_target = 32'h80;
    step();
    br_flush = 1'b0;
    check_req("drain", 32'h100);
    check_eq("drain_inst_valid", {31'd0, inst_valid}, 32'd0);
    step();
    check_req("drain_wait", 32'h100);
    respond(32'h0000_0013);
    check_idle_outputs("drain_done");
    step();
    check_req("req_after_drain", 32'h80);

    // Flush coincident with the response: response dropped, go straight to IDLE.
    br_flush  = 1'b1;
    br_target = 32'h200;
    respond(32'h0030_0193);
    br_flush = 1'b0;
    check_idle_outputs("flush_resp");
    step();
    check_req("req_after_flush_resp", 32'h200);

    // rdy_in low for 3 cycles in WAIT: response and flush during freeze ignored.
    rdy_in = 1'b0;
    respond(32'h1111_2222);
    br_flush  = 1'b1;
    br_target = 32'h300;
    step();
    br_flush = 1'b0;
    step();
    check_req("freeze", 32'h200);
    check_eq("freeze_inst_valid", {31'd0, inst_valid}, 32'd0);
    rdy_in = 1'b1;
    respond(32'h0000_0013);
    check_inst("after_freeze", 32'h200, 32'h0000_0013, 1'b0);

    // Flush with dec_ready in HOLD: flush wins, bit 0 of target forced to 0.
    dec_ready    = 1'b1;
    pred_next_pc = 32'h204;
    br_flush     = 1'b1;
    br_target    = 32'h401;
    step();
    dec_ready = 1'b0;
    br_flush  = 1'b0;
    check_idle_outputs("flush_hold");
    step();
    check_req("req_after_flush_hold", 32'h400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
